// File: rtl/cmlk_imaging_pkg.sv
// rtl/cmlk_imaging_pkg.sv - shared types and reg0 bit positions for the imaging control slice
package cmlk_imaging_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        EXPOSE = 2'd2,
        GAP    = 2'd3
    } trig_state_t;

    typedef enum logic [1:0] {
        FREE_RUN = 2'd0,
        BURST    = 2'd1,
        EXTERNAL = 2'd2
    } trig_mode_t;

    localparam int REG0_ENABLE_BIT = 0;
    localparam int REG0_MODE_LSB   = 1;
    localparam int REG0_MODE_MSB   = 2;
    localparam int REG0_START_BIT  = 3;

endpackage

// File: rtl/cmlk_trigger_gen_if.sv
// rtl/cmlk_trigger_gen_if.sv - register-slave to trigger-generator config/status bundle
interface cmlk_trigger_gen_if #(
    parameter int CNT_W       = 32,
    parameter int FRAME_CNT_W = 16
);
    logic                   cfg_enable;
    logic [1:0]             cfg_mode;
    logic                   cfg_start;
    logic [CNT_W-1:0]       cfg_period;
    logic [CNT_W-1:0]       cfg_exposure;
    logic [FRAME_CNT_W-1:0] cfg_burst_len;
    logic                   cc_trig;
    logic                   frame_start;
    logic                   busy;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   err_cfg;
    logic                   trig_overrun;

    modport master (
        output cfg_enable, cfg_mode, cfg_start, cfg_period, cfg_exposure, cfg_burst_len,
        input  cc_trig, frame_start, busy, frame_cnt, err_cfg, trig_overrun
    );

    modport slave (
        input  cfg_enable, cfg_mode, cfg_start, cfg_period, cfg_exposure, cfg_burst_len,
        output cc_trig, frame_start, busy, frame_cnt, err_cfg, trig_overrun
    );
endinterface

// File: rtl/cmlk_trig_sync.sv
// rtl/cmlk_trig_sync.sv - 2-FF synchroniser plus registered rising-edge pulse for ext_trig
module cmlk_trig_sync (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic rise
);
    logic [2:0] sh;

    // sh[1:0] is the synchroniser; sh[2] only remembers the previous synchronised level
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh   <= '0;
            rise <= 1'b0;
        end else begin
            sh   <= {sh[1:0], async_in};
            rise <= sh[1] & ~sh[2];
        end
    end
endmodule

// File: rtl/cmlk_trigger_gen.sv
// rtl/cmlk_trigger_gen.sv - Camera Link CC1 trigger/exposure sequencer; external trigger mode built under CMLK_TRIG_EXT_EN
module cmlk_trigger_gen
    import cmlk_imaging_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                ext_trig,
    cmlk_trigger_gen_if.slave   bus
);

    trig_state_t            state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic                   cc_q, fs_q, fs_d;
    logic [FRAME_CNT_W-1:0] fcnt, fcnt_d;
    logic                   err_q, err_d;
    logic                   ovr_q, ovr_d;
    logic                   load_shadow;
    logic                   cfg_ok;
    logic                   trig_rise;

    trig_mode_t             sh_mode;
    logic [CNT_W-1:0]       sh_period;
    logic [CNT_W-1:0]       sh_exposure;
    logic [FRAME_CNT_W-1:0] sh_burst;

`ifdef CMLK_TRIG_EXT_EN
    cmlk_trig_sync u_sync (
        .clk      (ACLK),
        .resetn   (ARESETN),
        .async_in (ext_trig),
        .rise     (trig_rise)
    );
`else
    logic unused_ext_trig;
    assign unused_ext_trig = ext_trig;
    assign trig_rise       = 1'b0;
`endif

    always_comb begin
        cfg_ok = (bus.cfg_exposure != '0) && (bus.cfg_exposure < bus.cfg_period)
                 && (bus.cfg_mode != 2'd3);
        if ((bus.cfg_mode == BURST) && (bus.cfg_burst_len == '0))
            cfg_ok = 1'b0;
`ifndef CMLK_TRIG_EXT_EN
        if (bus.cfg_mode == EXTERNAL)
            cfg_ok = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        fs_d        = 1'b0;
        fcnt_d      = fcnt;
        err_d       = err_q;
        ovr_d       = ovr_q;
        load_shadow = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cfg_start && bus.cfg_enable) begin
                    if (cfg_ok) begin
                        load_shadow = 1'b1;
                        err_d       = 1'b0;
                        ovr_d       = 1'b0;
                        if (bus.cfg_mode == EXTERNAL) begin
                            state_d = ARMED;
                            fcnt_d  = '0;
                        end else begin
                            state_d = EXPOSE;
                            cnt_d   = bus.cfg_exposure - CNT_W'(1);
                            fs_d    = 1'b1;
                            fcnt_d  = FRAME_CNT_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (!bus.cfg_enable) begin
                    state_d = IDLE;
                end else if (trig_rise) begin
                    state_d = EXPOSE;
                    cnt_d   = sh_exposure - CNT_W'(1);
                    fs_d    = 1'b1;
                    fcnt_d  = fcnt + FRAME_CNT_W'(1);
                end
            end
            EXPOSE: begin
                if (trig_rise)
                    ovr_d = 1'b1;
                if (cnt == '0) begin
                    state_d = GAP;
                    cnt_d   = sh_period - sh_exposure - CNT_W'(1);
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (trig_rise)
                    ovr_d = 1'b1;
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else if (!bus.cfg_enable) begin
                    state_d = IDLE;
                end else if (sh_mode == EXTERNAL) begin
                    state_d = ARMED;
                end else if ((sh_mode == BURST) && (fcnt == sh_burst)) begin
                    state_d = IDLE;
                end else begin
                    state_d = EXPOSE;
                    cnt_d   = sh_exposure - CNT_W'(1);
                    fs_d    = 1'b1;
                    fcnt_d  = fcnt + FRAME_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state       <= IDLE;
            cnt         <= '0;
            cc_q        <= 1'b0;
            fs_q        <= 1'b0;
            fcnt        <= '0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            sh_mode     <= FREE_RUN;
            sh_period   <= '0;
            sh_exposure <= '0;
            sh_burst    <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            cc_q  <= (state_d == EXPOSE);
            fs_q  <= fs_d;
            fcnt  <= fcnt_d;
            err_q <= err_d;
            ovr_q <= ovr_d;
            if (load_shadow) begin
                sh_mode     <= trig_mode_t'(bus.cfg_mode);
                sh_period   <= bus.cfg_period;
                sh_exposure <= bus.cfg_exposure;
                sh_burst    <= bus.cfg_burst_len;
            end
        end
    end

    assign bus.cc_trig      = cc_q;
    assign bus.frame_start  = fs_q;
    assign bus.busy         = (state != IDLE);
    assign bus.frame_cnt    = fcnt;
    assign bus.err_cfg      = err_q;
    assign bus.trig_overrun = ovr_q;

endmodule

// File: tb/tb_cmlk_trigger_gen.sv
// tb/tb_cmlk_trigger_gen.sv - directed scoreboard bench for cmlk_trigger_gen
module tb_cmlk_trigger_gen;
    import cmlk_imaging_pkg::*;

    logic ACLK = 1'b0;
    logic ARESETN;
    logic ext_trig;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;
    int   cc_run = 0;
    int   exp_fs_q[$];
    int   exp_w_q[$];

    cmlk_trigger_gen_if #(.CNT_W(32), .FRAME_CNT_W(16)) bus ();

    cmlk_trigger_gen #(.CNT_W(32), .FRAME_CNT_W(16)) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .ext_trig (ext_trig),
        .bus      (bus)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // frame_start cycles and CC1 high-run lengths are popped against what the steps pushed
    always @(negedge ACLK) begin
        if (bus.frame_start === 1'b1) begin
            if (exp_fs_q.size() == 0) check("frame_unexpected", exp_fs_q.size(), 1);
            else check("frame_start_cycle", cyc, exp_fs_q.pop_front());
        end
        if (bus.cc_trig === 1'b1) begin
            cc_run++;
        end else if (cc_run != 0) begin
            if (exp_w_q.size() == 0) check("cc_pulse_unexpected", exp_w_q.size(), 1);
            else check("cc_pulse_width", cc_run, exp_w_q.pop_front());
            cc_run = 0;
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic do_start(output int c0);
        @(posedge ACLK);
        #1;
        bus.cfg_start = 1'b1;
        c0 = cyc;
        @(posedge ACLK);
        #1;
        bus.cfg_start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge ACLK);
        #1;
        ARESETN = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
    endtask

    task automatic expect_frames(input int first, input int n, input int period, input int expo);
        for (int i = 0; i < n; i++) begin
            exp_fs_q.push_back(first + i * period);
            exp_w_q.push_back(expo);
        end
    endtask

    task automatic wait_idle(input int max_cyc, output int fall);
        int n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (bus.busy === 1'b1 && n < max_cyc);
        fall = cyc;
        check("busy_settled", bus.busy, 0);
    endtask

    task automatic set_cfg(input logic [1:0] mode, input int period, input int expo, input int blen);
        bus.cfg_mode      = mode;
        bus.cfg_period    = period;
        bus.cfg_exposure  = expo;
        bus.cfg_burst_len = 16'(blen);
    endtask

    initial begin
        int c0, c1, k, fc, n_inv;
        int inv_mode[5];
        int inv_per[5];
        int inv_exp[5];
        int inv_bl[5];

        ARESETN           = 1'b0;
        ext_trig          = 1'b0;
        bus.cfg_enable    = 1'b0;
        bus.cfg_start     = 1'b0;
        set_cfg(2'd0, 0, 0, 0);
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_cc_trig", bus.cc_trig, 0);
        check("rst_frame_start", bus.frame_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_cnt", bus.frame_cnt, 0);
        check("rst_err_cfg", bus.err_cfg, 0);
        check("rst_trig_overrun", bus.trig_overrun, 0);
        ARESETN        = 1'b1;
        bus.cfg_enable = 1'b1;

        // counted burst
        set_cfg(2'd1, 10, 3, 4);
        do_start(c0);
        expect_frames(c0 + 1, 4, 10, 3);
        @(negedge ACLK);
        check("burst_busy_rise", bus.busy, 1);
        check("burst_cc_first", bus.cc_trig, 1);
        wait_idle(200, fc);
        check("burst_busy_fall_cycle", fc, c0 + 41);
        check("burst_frame_cnt", bus.frame_cnt, 4);

        // free-run stopped by enable drop during frame 3 exposure
        set_cfg(2'd0, 8, 2, 0);
        do_start(c0);
        expect_frames(c0 + 1, 3, 8, 2);
        wait_cyc(c0 + 17);
        bus.cfg_enable = 1'b0;
        wait_idle(100, fc);
        check("freerun_busy_fall_cycle", fc, c0 + 25);
        check("freerun_frame_cnt", bus.frame_cnt, 3);
        bus.cfg_enable = 1'b1;

        // rejected configurations
        inv_mode = '{0, 0, 3, 1, 2};
        inv_per  = '{5, 10, 10, 10, 10};
        inv_exp  = '{5, 0, 3, 3, 3};
        inv_bl   = '{1, 1, 1, 0, 1};
`ifdef CMLK_TRIG_EXT_EN
        n_inv = 4;
`else
        n_inv = 5;
`endif
        for (int i = 0; i < n_inv; i++) begin
            do_reset();
            set_cfg(2'(inv_mode[i]), inv_per[i], inv_exp[i], inv_bl[i]);
            @(negedge ACLK);
            check("invalid_err_before", bus.err_cfg, 0);
            do_start(c0);
            @(negedge ACLK);
            check("invalid_err_set", bus.err_cfg, 1);
            repeat (3) @(negedge ACLK);
            check("invalid_busy", bus.busy, 0);
            check("invalid_cc_trig", bus.cc_trig, 0);
        end

`ifdef CMLK_TRIG_EXT_EN
        // external trigger with an overrun edge
        set_cfg(2'd2, 20, 4, 0);
        do_start(c0);
        @(negedge ACLK);
        check("ext_err_cleared", bus.err_cfg, 0);
        check("ext_armed_busy", bus.busy, 1);
        wait_cyc(c0 + 3);
        ext_trig = 1'b1;
        k = cyc;
        exp_fs_q.push_back(k + 4);
        exp_w_q.push_back(4);
        wait_cyc(k + 2);
        ext_trig = 1'b0;
        wait_cyc(k + 6);
        ext_trig = 1'b1;
        wait_cyc(k + 8);
        ext_trig = 1'b0;
        wait_cyc(k + 9);
        @(negedge ACLK);
        check("ext_overrun_not_yet", bus.trig_overrun, 0);
        @(negedge ACLK);
        check("ext_overrun_set", bus.trig_overrun, 1);
        wait_cyc(k + 30);
        ext_trig = 1'b1;
        exp_fs_q.push_back(k + 34);
        exp_w_q.push_back(4);
        wait_cyc(k + 32);
        ext_trig = 1'b0;
        wait_cyc(k + 60);
        bus.cfg_enable = 1'b0;
        wait_idle(50, fc);
        check("ext_armed_exit_cycle", fc, k + 61);
        check("ext_frame_cnt", bus.frame_cnt, 2);
        check("ext_overrun_sticky", bus.trig_overrun, 1);
        bus.cfg_enable = 1'b1;
`endif

        // shadowed period: mid-burst write only affects the next start
        set_cfg(2'd1, 10, 3, 3);
        do_start(c0);
        expect_frames(c0 + 1, 3, 10, 3);
        @(negedge ACLK);
        check("shadow_err_cleared", bus.err_cfg, 0);
        wait_cyc(c0 + 5);
        bus.cfg_period = 50;
        wait_idle(100, fc);
        check("shadow_old_period_fall", fc, c0 + 31);
        bus.cfg_burst_len = 16'd2;
        do_start(c1);
        expect_frames(c1 + 1, 2, 50, 3);
        wait_idle(300, fc);
        check("shadow_new_period_fall", fc, c1 + 101);
        check("shadow_frame_cnt", bus.frame_cnt, 2);

        // one-cycle reset while CC1 is high
        set_cfg(2'd0, 8, 4, 0);
        do_start(c0);
        exp_fs_q.push_back(c0 + 1);
        exp_w_q.push_back(2);
        wait_cyc(c0 + 2);
        ARESETN = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        check("midrst_cc_trig", bus.cc_trig, 0);
        check("midrst_frame_start", bus.frame_start, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_frame_cnt", bus.frame_cnt, 0);
        check("midrst_err_cfg", bus.err_cfg, 0);
        check("midrst_trig_overrun", bus.trig_overrun, 0);
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        check("midrst_stays_idle", bus.busy, 0);

        check("frames_drained", exp_fs_q.size(), 0);
        check("pulses_drained", exp_w_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
